// File: rtl/mem_responder.sv
// mem_responder: memory-strobe responder with programmable wait states, internal word RAM
// and one-cycle ready/err pulses. Define IO_REG_EN to map an I/O register at IO_ADDR.
module mem_responder #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DEPTH_LOG2  = 10,
    parameter int unsigned           WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR     = ADDR_WIDTH'(16'hFFFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] io_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  busy,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] io_out
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
`ifdef IO_REG_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        wait_cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic                    accept;
    logic                    access;
    logic                    ready_d;
    logic                    err_d;
    logic                    busy_d;
    logic                    io_match;
    logic                    io_hit;
    logic                    in_ram;
    logic                    oor;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Address decode of the latched request; the I/O register wins over RAM.
    assign io_match = (addr_q == IO_ADDR);
    assign io_hit   = IO_EN && io_match;
    assign in_ram   = 32'(addr_q) < DEPTH;
    assign oor      = !in_ram && !io_hit;
    assign idx      = addr_q[DEPTH_LOG2-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (memread ^ memwrite) begin
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / control decode; ready and err are registered so they appear in DONE.
    always_comb begin
        accept  = 1'b0;
        access  = 1'b0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = wait_cnt_q;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                accept = memread ^ memwrite;
                err_d  = memread & memwrite;
                if (accept) begin
                    cnt_d = CNT_W'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                cnt_d = wait_cnt_q - CNT_W'(1);
            end
            S_ACCESS: begin
                access  = 1'b1;
                ready_d = 1'b1;
                err_d   = oor;
            end
            default: begin
            end
        endcase
    end

    // Request latch, read data and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= '0;
            rdata      <= '0;
            ready      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            io_out     <= '0;
        end else begin
            ready      <= ready_d;
            err        <= err_d;
            busy       <= busy_d;
            wait_cnt_q <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                write_q <= memwrite;
            end
            if (access && !write_q) begin
                if (io_hit) begin
                    rdata <= io_in;
                end else if (in_ram) begin
                    rdata <= mem[idx];
                end else begin
                    rdata <= '0;
                end
            end
            if (access && write_q && io_hit) begin
                io_out <= wdata_q;
            end
        end
    end

    // RAM write port; contents survive reset and out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (access && write_q && in_ram && !io_hit) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (0, 1 and 4 wait states) driven in lockstep,
// checked by a queue-based scoreboard against an array model of the memory map.
module tb_mem_responder;

    localparam int NL = 3;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] io_in;
    logic [15:0] rdata_v  [NL];
    logic        ready_v  [NL];
    logic        busy_v   [NL];
    logic        err_v    [NL];
    logic [15:0] io_out_v [NL];

    typedef struct packed {
        logic        both;
        logic        rd;
        logic        err;
        logic [15:0] rdata;
        logic [15:0] io;
        logic [31:0] acc;
    } exp_t;

    exp_t        expq [NL][$];
    logic [15:0] mem_m [1024];
    logic [15:0] io_m;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 4;
    endfunction

    function automatic logic is_io(input logic [15:0] a);
`ifdef IO_REG_EN
        return a == 16'hFFFF;
`else
        return 1'b0;
`endif
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned LW = wait_of(g);
        mem_responder #(
            .DATA_WIDTH (16),
            .ADDR_WIDTH (16),
            .DEPTH_LOG2 (10),
            .WAIT_CYCLES(LW),
            .IO_ADDR    (16'hFFFF)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .memread (memread),
            .memwrite(memwrite),
            .addr    (addr),
            .wdata   (wdata),
            .io_in   (io_in),
            .rdata   (rdata_v[g]),
            .ready   (ready_v[g]),
            .busy    (busy_v[g]),
            .err     (err_v[g]),
            .io_out  (io_out_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int lane, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s lane%0d: got %h expected %h (cycle %0d)", name, lane, act, exp, cyc);
    endtask

    // Monitor: busy every cycle, and a pop/compare whenever a response is due or seen.
    task automatic mon_lane(input int i);
        exp_t e;
        logic exp_busy;
        int   due;
        exp_busy = (expq[i].size() > 0) && !expq[i][0].both;
        check("busy", i, 32'(busy_v[i]), 32'(exp_busy));
        if (expq[i].size() == 0) begin
            if (ready_v[i] || err_v[i])
                check("spurious_resp", i, {30'd0, ready_v[i], err_v[i]}, 32'd0);
        end else begin
            e   = expq[i][0];
            due = e.both ? int'(e.acc) : int'(e.acc) + wait_of(i) + 1;
            if (ready_v[i] || err_v[i] || cyc >= due) begin
                void'(expq[i].pop_front());
                check("resp_cycle", i, 32'(cyc), 32'(due));
                check("ready", i, 32'(ready_v[i]), 32'(!e.both));
                check("err", i, 32'(err_v[i]), 32'(e.err));
                if (e.rd && !e.both) check("rdata", i, 32'(rdata_v[i]), 32'(e.rdata));
                check("io_out", i, 32'(io_out_v[i]), 32'(e.io));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) mon_lane(i);
    end

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < NL; i++) begin
            check("drain", i, 32'(expq[i].size()), 32'd0);
            expq[i].delete();
        end
    endtask

    // One transaction: strobe for a single accept cycle, predict, then wait for all lanes.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d);
        exp_t e;
        logic oor;
        @(negedge clk);
        memread  = rd;
        memwrite = wr;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        memread  = 1'b0;
        memwrite = 1'b0;
        oor      = (a >= 16'd1024) && !is_io(a);
        e        = '0;
        e.acc    = 32'(cyc);
        e.both   = rd & wr;
        e.rd     = rd;
        if (rd & wr) begin
            e.err = 1'b1;
        end else begin
            e.err = oor;
            if (wr && !oor) begin
                if (is_io(a)) io_m = d;
                else mem_m[a[9:0]] = d;
            end
            if (rd) e.rdata = oor ? 16'h0 : is_io(a) ? io_in : mem_m[a[9:0]];
        end
        e.io = io_m;
        for (int i = 0; i < NL; i++) expq[i].push_back(e);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout lane-1: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] a;
        logic        rd;
        logic        wr;
        int          r;
        reset    = 1'b1;
        memread  = 1'b0;
        memwrite = 1'b0;
        addr     = '0;
        wdata    = '0;
        io_in    = 16'h00A5;
        io_m     = '0;
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) begin
            check("rst_ready", i, 32'(ready_v[i]), 32'd0);
            check("rst_err", i, 32'(err_v[i]), 32'd0);
            check("rst_busy", i, 32'(busy_v[i]), 32'd0);
            check("rst_rdata", i, 32'(rdata_v[i]), 32'd0);
            check("rst_io_out", i, 32'(io_out_v[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 32; k++) issue(1'b0, 1'b1, 16'(k), 16'($urandom));

        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        issue(1'b1, 1'b1, 16'h0010, 16'h1111);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);

        issue(1'b1, 1'b0, 16'h0400, 16'h0000);
        issue(1'b0, 1'b1, 16'h0400, 16'h7777);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000);

        // Reset during the wait phase of a write abandons it.
        issue(1'b0, 1'b1, 16'h0020, 16'h1234);
        @(negedge clk);
        memwrite = 1'b1;
        addr     = 16'h0020;
        wdata    = 16'hDEAD;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        reset    = 1'b0;
        io_m     = '0;
        #1;
        for (int i = 0; i < NL; i++) begin
            check("midrst_ready", i, 32'(ready_v[i]), 32'd0);
            check("midrst_busy", i, 32'(busy_v[i]), 32'd0);
            check("midrst_rdata", i, 32'(rdata_v[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(1'b1, 1'b0, 16'h0020, 16'h0000);

        io_in = 16'h00A5;
        issue(1'b0, 1'b1, 16'hFFFF, 16'h5A5A);
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0000);

        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 6) a = 16'($urandom_range(0, 31));
            else if (r == 7) a = 16'h0400 | 16'($urandom_range(0, 31));
            else if (r == 8) a = 16'hFFFF;
            else a = 16'($urandom_range(1024, 65534));
            r  = int'($urandom_range(0, 9));
            rd = (r == 0) || (r >= 5);
            wr = (r <= 4);
            io_in = 16'($urandom);
            issue(rd, wr, a, 16'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
